// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : calc_sequencer
// Purpose : Register-mapped command sequencer between an I2C byte interface
//           and a start/done ALU; latches result, status and raises irq.
// Rev     : 1.0
// ============================================================================
module calc_sequencer #(
  parameter int DATA_W  = 8,
  parameter int NUM_OPS = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reg_wr,
  input  logic                reg_rd,
  input  logic [2:0]          reg_addr,
  input  logic [7:0]          reg_wdata,
  output logic [7:0]          reg_rdata,
  output logic                alu_start,
  output logic [2:0]          alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  input  logic                alu_err,
  output logic                irq
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [2:0] A_OPA    = 3'd0;
  localparam logic [2:0] A_OPB    = 3'd1;
  localparam logic [2:0] A_OPCODE = 3'd2;
  localparam logic [2:0] A_CTRL   = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_RES_L  = 3'd5;
  localparam logic [2:0] A_RES_H  = 3'd6;

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic [2:0]          r_opcode;
  logic [2*DATA_W-1:0] r_res;
  logic                r_done;
  logic                r_err;
  logic                r_tmo;
  logic                r_alu_err;
  logic                r_irq;
  logic [7:0]          r_cnt;

  logic w_busy;
  logic w_go;
  logic w_clr;
  logic w_op_valid;
  logic w_go_ok;
  logic w_go_bad;
  logic w_go_busy;
  logic w_opnd_wr;
  logic w_opnd_drop;
  logic w_complete;
  logic w_timeout;
  logic w_stat_rd;

  assign w_busy      = (r_state != S_IDLE);
  assign w_go        = reg_wr && (reg_addr == A_CTRL) && reg_wdata[0];
  assign w_clr       = reg_wr && (reg_addr == A_CTRL) && reg_wdata[1];
  assign w_op_valid  = (int'(r_opcode) < NUM_OPS);
  assign w_go_ok     = w_go && !w_busy && w_op_valid;
  assign w_go_bad    = w_go && !w_busy && !w_op_valid;
  assign w_go_busy   = w_go && w_busy;
  assign w_opnd_wr   = reg_wr && (reg_addr <= A_OPCODE);
  assign w_opnd_drop = w_opnd_wr && w_busy;
  assign w_complete  = (r_state == S_WAIT) && alu_done;
  assign w_timeout   = (r_state == S_WAIT) && !alu_done && (r_cnt == C_CNT_LAST);
  assign w_stat_rd   = reg_rd && (reg_addr == A_STATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go_ok) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (w_complete || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_start = 1'b0;
    if (r_state == S_ISSUE) alu_start = 1'b1;
  end

  // Operands only change while idle so the ALU sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_opcode <= '0;
    end else if (w_opnd_wr && !w_busy) begin
      case (reg_addr)
        A_OPA:    r_opa    <= DATA_W'(reg_wdata);
        A_OPB:    r_opb    <= DATA_W'(reg_wdata);
        A_OPCODE: r_opcode <= reg_wdata[2:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Clears are applied before sets so a coincident set always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_tmo     <= 1'b0;
      r_alu_err <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_err <= (r_err && !w_clr) || w_opnd_drop || w_go_busy || w_go_bad || w_timeout;
      r_tmo <= (r_tmo && !w_clr) || w_timeout;
      r_irq <= w_complete || w_timeout || w_go_bad;
      if (w_complete) begin
        r_res     <= alu_result;
        r_done    <= 1'b1;
        r_alu_err <= alu_err;
      end else begin
        if (w_go_ok || w_stat_rd) r_done <= 1'b0;
        if (w_go_ok) r_alu_err <= 1'b0;
      end
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      A_OPA:    reg_rdata = 8'(r_opa);
      A_OPB:    reg_rdata = 8'(r_opb);
      A_OPCODE: reg_rdata = {5'b00000, r_opcode};
      A_STATUS: reg_rdata = {3'b000, r_alu_err, r_tmo, r_err, r_done, w_busy};
      A_RES_L:  reg_rdata = 8'(r_res);
      A_RES_H:  reg_rdata = 8'(r_res >> 8);
      default:  reg_rdata = 8'h00;
    endcase
  end

  assign alu_op = r_opcode;
  assign alu_a  = r_opa;
  assign alu_b  = r_opb;
  assign irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_calc_sequencer
// Purpose : Directed plus randomized self-checking bench for calc_sequencer.
// Rev     : 1.0
// ============================================================================
module tb_calc_sequencer;
  localparam int DATA_W  = 8;
  localparam int NUM_OPS = 6;
  localparam int TIMEOUT = 255;

  logic                clk        = 1'b0;
  logic                rst_n      = 1'b0;
  logic                reg_wr     = 1'b0;
  logic                reg_rd     = 1'b0;
  logic [2:0]          reg_addr   = 3'd0;
  logic [7:0]          reg_wdata  = 8'h00;
  logic [7:0]          reg_rdata;
  logic                alu_start;
  logic [2:0]          alu_op;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic                alu_done   = 1'b0;
  logic [2*DATA_W-1:0] alu_result = '0;
  logic                alu_err    = 1'b0;
  logic                irq;

  calc_sequencer #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err), .irq(irq)
  );

  always #50 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;
  int irq_cnt   = 0;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (alu_start === 1'b1) start_cnt++;
    if (irq === 1'b1) irq_cnt++;
  end

  // Reference model: architectural register contents.
  logic [7:0]  m_opa, m_opb;
  logic [2:0]  m_opc;
  logic [15:0] m_res;
  bit          m_done, m_err, m_tmo, m_aerr;

  function automatic logic [7:0] m_status(input bit busy);
    return {3'b000, m_aerr, m_tmo, m_err, m_done, busy};
  endfunction

  task automatic model_reset;
    m_opa = 0; m_opb = 0; m_opc = 0; m_res = 0;
    m_done = 0; m_err = 0; m_tmo = 0; m_aerr = 0;
  endtask

  // Behavioural ALU used as the DUT's counterpart.
  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, output bit e);
    e = 0;
    case (op)
      3'd0: return 16'(a) + 16'(b);
      3'd1: return 16'(a) - 16'(b);
      3'd2: return 16'(a) * 16'(b);
      3'd3: begin
        if (b == 0) begin e = 1; return 16'hFFFF; end
        return 16'(a / b);
      end
      3'd4: return 16'(a & b);
      default: return 16'(a | b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    reg_wr = 1; reg_addr = a; reg_wdata = d;
    tick;
    reg_wr = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic rd_clr;
    reg_rd = 1; reg_addr = 3'd4;
    tick;
    reg_rd = 0;
    m_done = 0;
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    wr(3'd0, a); wr(3'd1, b); wr(3'd2, {5'b0, op});
    m_opa = a; m_opb = b; m_opc = op;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] d;
    rd(3'd0, d); check({tag, "/opa"},  d, m_opa);
    rd(3'd1, d); check({tag, "/opb"},  d, m_opb);
    rd(3'd2, d); check({tag, "/opc"},  d, {5'b0, m_opc});
    rd(3'd3, d); check({tag, "/ctrl"}, d, 8'h00);
    rd(3'd4, d); check({tag, "/stat"}, d, m_status(0));
    rd(3'd5, d); check({tag, "/resl"}, d, m_res[7:0]);
    rd(3'd6, d); check({tag, "/resh"}, d, m_res[15:8]);
    rd(3'd7, d); check({tag, "/unmp"}, d, 8'h00);
  endtask

  // Valid-opcode operation; done arrives lat cycles after alu_start.
  task automatic run_op(input int lat, input bit clr, input bit poke, input logic [2:0] paddr);
    int s0, i0;
    logic [7:0] d;
    logic [15:0] r;
    bit e;
    s0 = start_cnt; i0 = irq_cnt;
    r = ref_alu(m_opc, m_opa, m_opb, e);
    wr(3'd3, clr ? 8'h03 : 8'h01);
    if (clr) begin m_err = 0; m_tmo = 0; end
    m_done = 0; m_aerr = 0;
    check("start_pulse", alu_start, 1);
    check("alu_a", alu_a, m_opa);
    check("alu_b", alu_b, m_opb);
    check("alu_op", alu_op, m_opc);
    rd(3'd4, d); check("status_busy", d, m_status(1));
    tick;
    check("start_once", alu_start, 0);
    if (poke && lat >= 3) begin
      wr(paddr, 8'($urandom) | 8'h80);
      wr(3'd3, 8'h01);
      m_err = 1;
      repeat (lat - 3) tick;
    end else begin
      repeat (lat - 1) tick;
    end
    alu_done = 1; alu_result = r; alu_err = e;
    tick;
    alu_done = 0; alu_err = 0; alu_result = 16'($urandom);
    m_res = r; m_done = 1; m_aerr = e;
    check("irq_pulse", irq, 1);
    tick;
    check("irq_once", irq, 0);
    check("start_count", start_cnt - s0, 1);
    check("irq_count", irq_cnt - i0, 1);
    check_all("op");
  endtask

  task automatic run_bad;
    int s0, i0;
    s0 = start_cnt; i0 = irq_cnt;
    wr(3'd3, 8'h01);
    m_err = 1;
    check("bad_nostart", alu_start, 0);
    check("bad_irq", irq, 1);
    tick;
    check("bad_irq_once", irq, 0);
    check("bad_start_count", start_cnt - s0, 0);
    check("bad_irq_count", irq_cnt - i0, 1);
    check_all("bad");
  endtask

  initial begin
    logic [7:0] d;
    logic [15:0] r;
    bit e;
    int n, s0, i0;

    // Reset
    model_reset();
    repeat (3) tick;
    check("rst_start", alu_start, 0);
    check("rst_irq", irq, 0);
    check_all("rst_hold");
    rst_n = 1;
    repeat (2) tick;
    check_all("rst_rel");
    check("rst_start_cnt", start_cnt, 0);
    check("rst_irq_cnt", irq_cnt, 0);

    // Unmapped / read-only writes are ignored
    wr(3'd7, 8'hAA); wr(3'd4, 8'hFF); wr(3'd5, 8'h5A); wr(3'd6, 8'hA5);
    check_all("ro");

    // Normal operation
    set_ops(8'h0C, 8'h05, 3'd0);
    run_op(4, 0, 0, 3'd0);
    rd(3'd5, d); check("norm_resl", d, 8'h11);
    rd(3'd6, d); check("norm_resh", d, 8'h00);
    rd(3'd4, d); check("norm_stat", d, 8'h02);
    rd_clr();
    rd(3'd4, d); check("stat_rd_clears_done", d, 8'h00);

    // Busy rejection then CLR
    set_ops(8'h21, 8'h07, 3'd2);
    run_op(6, 0, 1, 3'd0);
    rd(3'd0, d); check("busy_opa_kept", d, 8'h21);
    wr(3'd3, 8'h02); m_err = 0; m_tmo = 0;
    check_all("clr");

    // Invalid opcode
    rd_clr();
    wr(3'd2, 8'h07); m_opc = 3'd7;
    run_bad();
    rd(3'd4, d); check("bad_stat", d, 8'h04);

    // GO+CLR with err set
    wr(3'd2, 8'h01); m_opc = 3'd1;
    run_op(2, 1, 0, 3'd0);

    // Timeout
    rd_clr();
    s0 = start_cnt; i0 = irq_cnt;
    wr(3'd3, 8'h01); m_done = 0; m_aerr = 0;
    n = 0;
    rd(3'd4, d);
    while (d[0] === 1'b1 && n < 600) begin
      tick; n++;
      rd(3'd4, d);
    end
    m_err = 1; m_tmo = 1;
    check("tmo_cycles", n, TIMEOUT + 1);
    check("tmo_stat", d, 8'h0C);
    check("tmo_irq", irq, 1);
    alu_done = 1; alu_result = 16'hDEAD; alu_err = 1;
    tick;
    alu_done = 0; alu_err = 0;
    tick;
    check("tmo_irq_count", irq_cnt - i0, 1);
    check("tmo_start_count", start_cnt - s0, 1);
    check_all("tmo_late");

    // STATUS read coincident with alu_done: done must stay set
    set_ops(8'h64, 8'h00, 3'd3);
    r = ref_alu(m_opc, m_opa, m_opb, e);
    wr(3'd3, 8'h01); m_done = 0; m_aerr = 0;
    tick; tick;
    alu_done = 1; alu_result = r; alu_err = e; reg_rd = 1; reg_addr = 3'd4;
    tick;
    alu_done = 0; alu_err = 0; reg_rd = 0;
    m_done = 1; m_res = r; m_aerr = e;
    tick;
    check_all("race_rd");

    // Reset mid-WAIT; the stale alu_done must be ignored
    set_ops(8'h99, 8'h33, 3'd4);
    wr(3'd3, 8'h01);
    tick; tick;
    rst_n = 0;
    #1;
    model_reset();
    check("rstw_start", alu_start, 0);
    check("rstw_irq", irq, 0);
    check_all("rstw");
    tick;
    rst_n = 1;
    i0 = irq_cnt;
    tick;
    alu_done = 1; alu_result = 16'hBEEF;
    tick;
    alu_done = 0;
    tick;
    check("rstw_irq_count", irq_cnt - i0, 0);
    check_all("rstw_late");

    // Randomized operations against the model
    for (int it = 0; it < 24; it++) begin
      set_ops(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      if (int'(m_opc) < NUM_OPS)
        run_op($urandom_range(1, 8), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)));
      else
        run_bad();
      case ($urandom_range(0, 3))
        0: rd_clr();
        1: begin wr(3'd3, 8'h02); m_err = 0; m_tmo = 0; end
        default: ;
      endcase
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
